// File: rtl/ct_ciu_snb_age_ctrl_8.sv
// ---------------------------------------------------------------------------
// ct_ciu_snb_age_ctrl_8
//
// Control block for an 8-entry snoop-buffer slice. Allocates entries
// (lowest free index first), keeps a full age matrix so every pair of live
// entries has a defined order, and picks the oldest requesting entry. The
// winner is held in a registered grant until the consumer accepts it.
//
// Ports:
//   forever_cpuclk  clock, all state changes on the rising edge
//   cpurst_b        synchronous active-low reset
//   alloc_vld       allocation request
//   alloc_rdy       a free entry exists
//   alloc_id        lowest-index free entry (0 when full)
//   rel_vld         per-entry release mask (multi-hot allowed)
//   req_vld         per-entry issue request
//   gnt_vld/gnt_id  registered grant valid / granted index
//   gnt_rdy         consumer accepts the grant
//   entry_vld       entry occupied mask
//   age_vect        flattened age matrix, row i at [8i+7:8i];
//                   bit j set means entry j is older than entry i
//   occ_cnt         occupied entry count, 0..8
//   full            all entries occupied
// ---------------------------------------------------------------------------
module ct_ciu_snb_age_ctrl_8 #(
    parameter int DEPTH = 8,
    parameter int IDW   = 3
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst_b,
    input  logic                   alloc_vld,
    output logic                   alloc_rdy,
    output logic [IDW-1:0]         alloc_id,
    input  logic [DEPTH-1:0]       rel_vld,
    input  logic [DEPTH-1:0]       req_vld,
    output logic                   gnt_vld,
    output logic [IDW-1:0]         gnt_id,
    input  logic                   gnt_rdy,
    output logic [DEPTH-1:0]       entry_vld,
    output logic [DEPTH*DEPTH-1:0] age_vect,
    output logic [IDW:0]           occ_cnt,
    output logic                   full
);

    logic [DEPTH-1:0] entryVld_q, entryVld_d;
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic [IDW:0]     occCnt_q, occCnt_d;
    logic             gntVld_q, gntVld_d;
    logic [IDW-1:0]   gntId_q, gntId_d;

    logic             allocFire;
    logic [DEPTH-1:0] allocOneHot;
    logic [DEPTH-1:0] relEff;
    logic [IDW:0]     relCnt;
    logic [DEPTH-1:0] effReq;
    logic [DEPTH-1:0] sel;
    logic [IDW-1:0]   selId;
    logic             ageOk;

    assign full      = (occCnt_q == (IDW+1)'(DEPTH));
    assign alloc_rdy = ~full;
    assign occ_cnt   = occCnt_q;
    assign entry_vld = entryVld_q;
    assign gnt_vld   = gntVld_q;
    assign gnt_id    = gntId_q;

    // Lowest-index free entry. Scanning from the top down lets the lowest
    // free index overwrite any higher one; stays 0 when nothing is free.
    always_comb begin
        alloc_id = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!entryVld_q[i]) alloc_id = IDW'(i);
        end
    end

    // Only releases of live entries count; releasing a free slot does nothing.
    // The allocation target comes from the pre-release mask, so a slot freed
    // this cycle cannot be handed out again in the same cycle.
    always_comb begin
        allocFire   = alloc_vld && alloc_rdy;
        allocOneHot = allocFire ? (DEPTH'(1) << alloc_id) : '0;
        relEff      = rel_vld & entryVld_q;
        entryVld_d  = (entryVld_q & ~relEff) | allocOneHot;
        relCnt      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            relCnt = relCnt + (IDW+1)'(relEff[i]);
        end
        occCnt_d = occCnt_q + (IDW+1)'(allocFire) - relCnt;
    end

    // Age matrix update: a released row is wiped, a new row marks every
    // surviving entry as older, and the new/released columns are cleared
    // everywhere so the new entry is youngest and released ones vanish.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (relEff[i]) begin
                age_d[i] = '0;
            end else if (allocOneHot[i]) begin
                age_d[i] = entryVld_q & ~relEff;
            end else begin
                age_d[i] = age_q[i] & ~relEff & ~allocOneHot;
            end
        end
    end

    // Oldest-first select: an entry wins if no other effective requester is
    // older than it. Entries releasing this cycle are excluded.
    always_comb begin
        effReq = req_vld & entryVld_q & ~rel_vld;
        selId  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = effReq[i] && !(|(effReq & age_q[i]));
            if (sel[i]) selId = IDW'(i);
        end
    end

    // Grant register: while a grant is stalled it holds without
    // re-arbitration, except that releasing the granted entry kills it.
    always_comb begin
        if (gntVld_q && !gnt_rdy) begin
            gntVld_d = ~rel_vld[gntId_q];
            gntId_d  = gntId_q;
        end else begin
            gntVld_d = |sel;
            gntId_d  = selId;
        end
    end

    // All state registers, with synchronous active-low reset.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            entryVld_q <= '0;
            occCnt_q   <= '0;
            gntVld_q   <= 1'b0;
            gntId_q    <= '0;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            entryVld_q <= entryVld_d;
            occCnt_q   <= occCnt_d;
            gntVld_q   <= gntVld_d;
            gntId_q    <= gntId_d;
            for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
        end
    end

    // Flatten the matrix for the downstream datapath.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_vect[i*DEPTH +: DEPTH] = age_q[i];
        end
    end

    // Pairwise ordering check: diagonal always clear, and exactly one
    // direction set for every pair of live entries.
    always_comb begin
        ageOk = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_q[i][i]) ageOk = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (i != j && entryVld_q[i] && entryVld_q[j] &&
                    (age_q[i][j] == age_q[j][i])) ageOk = 1'b0;
            end
        end
    end

    ageOrderAssert: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b) ageOk);
    selOneHotAssert: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b) $onehot0(sel));

endmodule

// File: tb/tb_ct_ciu_snb_age_ctrl_8.sv
// ---------------------------------------------------------------------------
// tb_ct_ciu_snb_age_ctrl_8
//
// Directed bench for the snoop-buffer age controller. Each test task drives
// its scenario and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ct_ciu_snb_age_ctrl_8;

    logic        forever_cpuclk;
    logic        cpurst_b;
    logic        alloc_vld;
    logic        alloc_rdy;
    logic [2:0]  alloc_id;
    logic [7:0]  rel_vld;
    logic [7:0]  req_vld;
    logic        gnt_vld;
    logic [2:0]  gnt_id;
    logic        gnt_rdy;
    logic [7:0]  entry_vld;
    logic [63:0] age_vect;
    logic [3:0]  occ_cnt;
    logic        full;

    int vectors;
    int miscompares;

    ct_ciu_snb_age_ctrl_8 dut (
        .forever_cpuclk(forever_cpuclk),
        .cpurst_b      (cpurst_b),
        .alloc_vld     (alloc_vld),
        .alloc_rdy     (alloc_rdy),
        .alloc_id      (alloc_id),
        .rel_vld       (rel_vld),
        .req_vld       (req_vld),
        .gnt_vld       (gnt_vld),
        .gnt_id        (gnt_id),
        .gnt_rdy       (gnt_rdy),
        .entry_vld     (entry_vld),
        .age_vect      (age_vect),
        .occ_cnt       (occ_cnt),
        .full          (full)
    );

    // Free-running clock, period 10.
    initial begin
        forever_cpuclk = 1'b0;
        forever #5 forever_cpuclk = ~forever_cpuclk;
    end

    // Advance one rising edge and settle just past it.
    task automatic applyStimulus();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic doReset();
        cpurst_b = 1'b0;
        applyStimulus();
        cpurst_b = 1'b1;
    endtask

    // Allocate all eight entries in order 0..7 (row i ends as (1<<i)-1).
    task automatic fillAll();
        alloc_vld = 1'b1;
        repeat (8) applyStimulus();
        alloc_vld = 1'b0;
    endtask

    task automatic test_reset();
        cpurst_b = 1'b0;
        applyStimulus();
        applyStimulus();
        vectors++; if (entry_vld !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_entry_vld got %h exp 00", entry_vld); end
        vectors++; if (age_vect !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_age got %h exp 0", age_vect); end
        vectors++; if (occ_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_occ got %0d exp 0", occ_cnt); end
        vectors++; if (gnt_vld !== 1'b0 || gnt_id !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_gnt got %b/%0d exp 0/0", gnt_vld, gnt_id); end
        vectors++; if (full !== 1'b0 || alloc_rdy !== 1'b1 || alloc_id !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_alloc got full=%b rdy=%b id=%0d exp 0/1/0", full, alloc_rdy, alloc_id); end
        cpurst_b = 1'b1;
    endtask

    task automatic test_alloc_fill();
        logic [7:0] expRow;
        alloc_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++; if (alloc_id !== 3'(i)) begin miscompares++; $display("[TB] FAIL fill_alloc_id got %0d exp %0d", alloc_id, i); end
            applyStimulus();
        end
        vectors++; if (full !== 1'b1 || occ_cnt !== 4'd8) begin miscompares++; $display("[TB] FAIL fill_full got full=%b occ=%0d exp 1/8", full, occ_cnt); end
        vectors++; if (age_vect[63:56] !== 8'h7F) begin miscompares++; $display("[TB] FAIL fill_row7 got %h exp 7f", age_vect[63:56]); end
        vectors++; if (age_vect[7:0] !== 8'h00) begin miscompares++; $display("[TB] FAIL fill_row0 got %h exp 00", age_vect[7:0]); end
        for (int i = 1; i < 7; i++) begin
            expRow = 8'((9'd1 << i) - 9'd1);
            vectors++; if (age_vect[i*8 +: 8] !== expRow) begin miscompares++; $display("[TB] FAIL fill_row%0d got %h exp %h", i, age_vect[i*8 +: 8], expRow); end
        end
        // Ninth request while full must be ignored.
        vectors++; if (alloc_rdy !== 1'b0 || alloc_id !== 3'd0) begin miscompares++; $display("[TB] FAIL full_alloc_port got rdy=%b id=%0d exp 0/0", alloc_rdy, alloc_id); end
        applyStimulus();
        alloc_vld = 1'b0;
        vectors++; if (occ_cnt !== 4'd8 || entry_vld !== 8'hFF || age_vect[63:56] !== 8'h7F || age_vect[31:24] !== 8'h07) begin miscompares++; $display("[TB] FAIL ninth_alloc got occ=%0d vld=%h age=%h exp 8/ff unchanged", occ_cnt, entry_vld, age_vect); end
    endtask

    task automatic test_release_realloc();
        rel_vld = 8'h08;
        applyStimulus();
        rel_vld = 8'h00;
        vectors++; if (entry_vld !== 8'hF7 || occ_cnt !== 4'd7) begin miscompares++; $display("[TB] FAIL rel3 got vld=%h occ=%0d exp f7/7", entry_vld, occ_cnt); end
        vectors++; if (age_vect[31:24] !== 8'h00 || age_vect[63:56] !== 8'h77 || age_vect[39:32] !== 8'h07) begin miscompares++; $display("[TB] FAIL rel3_age got r3=%h r4=%h r7=%h exp 00/07/77", age_vect[31:24], age_vect[39:32], age_vect[63:56]); end
        alloc_vld = 1'b1;
        #1;
        vectors++; if (alloc_id !== 3'd3 || alloc_rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL realloc_id got %0d rdy=%b exp 3/1", alloc_id, alloc_rdy); end
        applyStimulus();
        alloc_vld = 1'b0;
        vectors++; if (age_vect[31:24] !== 8'hF7) begin miscompares++; $display("[TB] FAIL realloc_row3 got %h exp f7", age_vect[31:24]); end
        vectors++; if (age_vect[63:56] !== 8'h77 || age_vect[39:32] !== 8'h07 || age_vect[15:8] !== 8'h01) begin miscompares++; $display("[TB] FAIL realloc_col3 got r1=%h r4=%h r7=%h exp 01/07/77", age_vect[15:8], age_vect[39:32], age_vect[63:56]); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL realloc_full got %b exp 1", full); end
    endtask

    task automatic test_arbitration();
        doReset();
        fillAll();
        req_vld = 8'hA4;
        gnt_rdy = 1'b1;
        applyStimulus();
        vectors++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd2) begin miscompares++; $display("[TB] FAIL arb_first got %b/%0d exp 1/2", gnt_vld, gnt_id); end
        req_vld = 8'hA0;
        applyStimulus();
        vectors++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd5) begin miscompares++; $display("[TB] FAIL arb_second got %b/%0d exp 1/5", gnt_vld, gnt_id); end
        req_vld = 8'h80;
        applyStimulus();
        vectors++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd7) begin miscompares++; $display("[TB] FAIL arb_third got %b/%0d exp 1/7", gnt_vld, gnt_id); end
        req_vld = 8'h00;
        applyStimulus();
        vectors++; if (gnt_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL arb_idle got %b exp 0", gnt_vld); end
    endtask

    task automatic test_hold();
        req_vld = 8'h20;
        gnt_rdy = 1'b0;
        applyStimulus();
        vectors++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd5) begin miscompares++; $display("[TB] FAIL hold_load got %b/%0d exp 1/5", gnt_vld, gnt_id); end
        req_vld = 8'h22;
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            vectors++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd5) begin miscompares++; $display("[TB] FAIL hold_cycle%0d got %b/%0d exp 1/5", c, gnt_vld, gnt_id); end
        end
        gnt_rdy = 1'b1;
        req_vld = 8'h02;
        applyStimulus();
        vectors++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd1) begin miscompares++; $display("[TB] FAIL hold_accept got %b/%0d exp 1/1", gnt_vld, gnt_id); end
        req_vld = 8'h00;
        applyStimulus();
        vectors++; if (gnt_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_idle got %b exp 0", gnt_vld); end
    endtask

    task automatic test_same_cycle();
        doReset();
        alloc_vld = 1'b1;
        repeat (4) applyStimulus();
        rel_vld = 8'h01;
        #1;
        vectors++; if (alloc_id !== 3'd4 || occ_cnt !== 4'd4) begin miscompares++; $display("[TB] FAIL same_alloc_id got %0d occ=%0d exp 4/4", alloc_id, occ_cnt); end
        applyStimulus();
        alloc_vld = 1'b0;
        rel_vld   = 8'h00;
        vectors++; if (occ_cnt !== 4'd4 || entry_vld !== 8'h1E) begin miscompares++; $display("[TB] FAIL same_state got occ=%0d vld=%h exp 4/1e", occ_cnt, entry_vld); end
        vectors++; if (age_vect[39:32] !== 8'h0E) begin miscompares++; $display("[TB] FAIL same_row4 got %h exp 0e", age_vect[39:32]); end
        vectors++; if (age_vect[31:24] !== 8'h06 || age_vect[7:0] !== 8'h00 || age_vect[15:8] !== 8'h00) begin miscompares++; $display("[TB] FAIL same_rows got r0=%h r1=%h r3=%h exp 00/00/06", age_vect[7:0], age_vect[15:8], age_vect[31:24]); end
    endtask

    task automatic test_grant_release();
        doReset();
        fillAll();
        req_vld = 8'h40;
        gnt_rdy = 1'b0;
        applyStimulus();
        vectors++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd6) begin miscompares++; $display("[TB] FAIL grel_load got %b/%0d exp 1/6", gnt_vld, gnt_id); end
        applyStimulus();
        vectors++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd6) begin miscompares++; $display("[TB] FAIL grel_hold got %b/%0d exp 1/6", gnt_vld, gnt_id); end
        rel_vld = 8'h40;
        applyStimulus();
        rel_vld = 8'h00;
        req_vld = 8'h00;
        vectors++; if (gnt_vld !== 1'b0) begin miscompares++; $display("[TB] FAIL grel_kill got %b exp 0", gnt_vld); end
        vectors++; if (entry_vld !== 8'hBF || occ_cnt !== 4'd7 || age_vect[55:48] !== 8'h00 || age_vect[63:56] !== 8'h3F) begin miscompares++; $display("[TB] FAIL grel_state got vld=%h occ=%0d r6=%h r7=%h exp bf/7/00/3f", entry_vld, occ_cnt, age_vect[55:48], age_vect[63:56]); end
    endtask

    task automatic test_reset_mid();
        alloc_vld = 1'b1;
        req_vld   = 8'h01;
        gnt_rdy   = 1'b0;
        applyStimulus();
        vectors++; if (gnt_vld !== 1'b1 || gnt_id !== 3'd0 || occ_cnt !== 4'd8) begin miscompares++; $display("[TB] FAIL mid_pre got %b/%0d occ=%0d exp 1/0/8", gnt_vld, gnt_id, occ_cnt); end
        cpurst_b = 1'b0;
        applyStimulus();
        vectors++; if (entry_vld !== 8'h00 || occ_cnt !== 4'd0 || age_vect !== 64'h0) begin miscompares++; $display("[TB] FAIL mid_state got vld=%h occ=%0d age=%h exp 0", entry_vld, occ_cnt, age_vect); end
        vectors++; if (gnt_vld !== 1'b0 || gnt_id !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_gnt got %b/%0d exp 0/0", gnt_vld, gnt_id); end
        vectors++; if (full !== 1'b0 || alloc_rdy !== 1'b1 || alloc_id !== 3'd0) begin miscompares++; $display("[TB] FAIL mid_alloc got %b/%b/%0d exp 0/1/0", full, alloc_rdy, alloc_id); end
        cpurst_b  = 1'b1;
        alloc_vld = 1'b0;
        req_vld   = 8'h00;
        applyStimulus();
    endtask

    // Run every scenario in order, then report.
    initial begin
        vectors     = 0;
        miscompares = 0;
        cpurst_b    = 1'b0;
        alloc_vld   = 1'b0;
        rel_vld     = 8'h00;
        req_vld     = 8'h00;
        gnt_rdy     = 1'b0;
        test_reset();
        test_alloc_fill();
        test_release_realloc();
        test_arbitration();
        test_hold();
        test_same_cycle();
        test_grant_release();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ct_ciu_snb_age_ctrl_8.md
Name: ct_ciu_snb_age_ctrl_8

Overview:
Control block for an 8-entry snoop-buffer slice. It allocates entries, maintains the per-entry age matrix, and performs oldest-first arbitration among requesting entries. The winner is held on a registered grant port until the downstream consumer accepts it. It feeds per-entry age vectors to the combinational oldest-select datapath and to downstream snoop-issue logic.

Parameters:
DEPTH, 8, number of entries (the design is fixed at 8; the parameter is for documentation and checking only)
IDW, 3, entry index width

Ports:
forever_cpuclk  in  1  clock; all state changes on the rising edge
cpurst_b  in  1  reset, synchronous, active-low
alloc_vld  in  1  allocation request
alloc_rdy  out  1  a free entry exists (!full)
alloc_id  out  3  entry index that will be allocated (lowest-index free entry)
rel_vld  in  8  per-entry release, one-hot or multi-hot
req_vld  in  8  per-entry issue request
gnt_vld  out  1  registered grant valid
gnt_id  out  3  granted entry index
gnt_rdy  in  1  consumer accepts the grant
entry_vld  out  8  entry occupied
age_vect  out  64  flattened age matrix; bits [8i+7:8i] are entry i's vector; bit j=1 means entry j is older than entry i
occ_cnt  out  4  number of occupied entries, 0..8
full  out  1  occ_cnt==8

Behaviour:
- Reset (cpurst_b==0 at a clock edge) sets:
  - entry_vld=0, age matrix=0, occ_cnt=0, gnt_vld=0, gnt_id=0.
  - Consequently full=0, alloc_rdy=1, alloc_id=0.
- Allocation:
  - An allocation fires when alloc_vld && alloc_rdy.
  - alloc_id is combinational: the lowest-index entry with entry_vld==0. It is 0 when full.
  - In the next cycle the allocated entry k has entry_vld[k]=1.
  - age row k becomes (entry_vld & ~rel_vld), i.e. every entry surviving this cycle is older than k.
  - Column k is cleared in all other rows, so the new entry is youngest.
  - alloc_vld while full is ignored: no state change.
- Release:
  - For each set bit rel_vld[j]: entry_vld[j] is cleared, row j is cleared, and column j is cleared in all rows, all in the next cycle.
  - Release of an invalid entry is a no-op.
- Same-cycle alloc and release:
  - Both take effect in the same cycle.
  - alloc_id is computed from the pre-release entry_vld, so a releasing entry is never reallocated in the same cycle.
  - occ_cnt_next = occ_cnt + alloc_fire - popcount(rel_vld & entry_vld).
- Invariant, checked by assertion: for valid i≠j, exactly one of age[i][j], age[j][i] is set. age[i][i]=0 always.
- Arbitration, combinational:
  - eff_req = req_vld & entry_vld & ~rel_vld.
  - sel[i] = eff_req[i] && !(|(eff_req & age_row_i)).
  - sel is one-hot or zero.
- Grant register:
  - When gnt_vld==0 or (gnt_vld && gnt_rdy), the register loads: gnt_vld<=|sel, gnt_id<=encode(sel). Grant latency is one cycle from the request.
  - When gnt_vld && !gnt_rdy, gnt_vld and gnt_id hold, with no re-arbitration, even if an older request arrives.
  - When the granted entry is released while gnt_vld && !gnt_rdy, gnt_vld clears next cycle. This takes priority over hold.
  - Back-to-back: on an accept cycle the next winner loads, excluding the just-accepted entry only if its req_vld has dropped. The requester must deassert req_vld in the cycle gnt_rdy is seen.
- Reset mid-operation: all state returns to reset values at the next edge regardless of pending grant or allocation.

Test Plan:
- Reset, then alloc_vld held 8 cycles:
  - alloc_id sequence is 0..7.
  - full=1 after the 8th cycle; occ_cnt=8.
  - age row 7 = 0x7F; row 0 = 0x00.
  - A 9th alloc_vld is ignored.
- Full buffer; release entry 3 only; then alloc:
  - alloc_id=3.
  - Row 3 = 0xF7 & ~0x08 = 0xF7 (all others older).
  - Column 3 is cleared in every other row.
- Entries allocated in order 0..7; req_vld=0xA4 (entries 2,5,7), gnt_rdy=1:
  - Cycle+1: gnt_id=2.
  - With req 2 dropped: then gnt_id=5, then gnt_id=7.
- gnt_vld=1, gnt_id=5, gnt_rdy=0 for 4 cycles while an older entry 1 starts requesting:
  - gnt_id stays 5.
  - After accept, gnt_id=1.
- Same-cycle alloc with rel_vld=0x01, occ_cnt=4 (entries 0..3):
  - alloc_id=4.
  - Next cycle: occ_cnt=4, entry_vld=0x1E, row 4=0x0E.
- Pending grant for entry 6 with gnt_rdy=0, then rel_vld[6]=1:
  - gnt_vld=0 next cycle.
  - Separately: cpurst_b=0 mid-burst -> all outputs at reset values next edge.
